// File: rtl/bbox_sample_iterator.sv
// Walks a triangle's grid-aligned bounding box in raster order (x fastest),
// emitting one sample per cycle for the per-sample edge test.
module bbox_sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]           color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]             box_R13S,
  input  logic [4:0]                              step_lg2_R13U,
  input  logic                                    validTri_R13H,
  output logic                                    halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]           color_R14U,
  output logic [1:0][SIGFIG-1:0]                  sample_R14S,
  output logic                                    validSamp_R14H
);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_TEST = 1'b1
  } state_e;

  state_e                                  state_r, state_s;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_r, tri_s;
  logic [COLORS-1:0][SIGFIG-1:0]           color_r, color_s;
  logic [SIGFIG-1:0]                       ll_x_r, ll_x_s;
  logic [SIGFIG-1:0]                       ur_x_r, ur_x_s;
  logic [SIGFIG-1:0]                       ur_y_r, ur_y_s;
  logic [4:0]                              step_lg2_r, step_lg2_s;
  logic [SIGFIG-1:0]                       samp_x_r, samp_x_s;
  logic [SIGFIG-1:0]                       samp_y_r, samp_y_s;
  logic                                    valid_r, valid_s;
  logic                                    halt_r, halt_s;

  logic [RADIX:0]                          step_s;
  logic signed [SIGFIG:0]                  step_ext_s;
  logic signed [SIGFIG:0]                  next_x_s;
  logic signed [SIGFIG:0]                  next_y_s;
  logic signed [SIGFIG:0]                  ur_x_ext_s;
  logic signed [SIGFIG:0]                  ur_y_ext_s;
  logic                                    x_fits_s;
  logic                                    y_fits_s;
  logic                                    box_ok_s;

  assign tri_R14S       = tri_r;
  assign color_R14U     = color_r;
  assign sample_R14S[0] = samp_x_r;
  assign sample_R14S[1] = samp_y_r;
  assign validSamp_R14H = valid_r;
  assign halt_RnnnnL    = halt_r;

  // Step arithmetic: sums carry one extra bit so a sum past the top of the
  // signed range cannot wrap negative and pass the "<=" test.
  always_comb begin
    step_s     = {{RADIX{1'b0}}, 1'b1} << step_lg2_r;
    step_ext_s = {{(SIGFIG-RADIX){1'b0}}, step_s};
    next_x_s   = $signed({samp_x_r[SIGFIG-1], samp_x_r}) + step_ext_s;
    next_y_s   = $signed({samp_y_r[SIGFIG-1], samp_y_r}) + step_ext_s;
    ur_x_ext_s = $signed({ur_x_r[SIGFIG-1], ur_x_r});
    ur_y_ext_s = $signed({ur_y_r[SIGFIG-1], ur_y_r});
    x_fits_s   = (next_x_s <= ur_x_ext_s);
    y_fits_s   = (next_y_s <= ur_y_ext_s);
    box_ok_s   = ($signed(box_R13S[0][0]) <= $signed(box_R13S[1][0])) &&
                 ($signed(box_R13S[0][1]) <= $signed(box_R13S[1][1]));
  end

  // Next-state and next-output logic for the WAIT/TEST walk.
  always_comb begin
    state_s    = state_r;
    tri_s      = tri_r;
    color_s    = color_r;
    ll_x_s     = ll_x_r;
    ur_x_s     = ur_x_r;
    ur_y_s     = ur_y_r;
    step_lg2_s = step_lg2_r;
    samp_x_s   = samp_x_r;
    samp_y_s   = samp_y_r;
    valid_s    = valid_r;
    halt_s     = halt_r;
    case (state_r)
      ST_WAIT: begin
        valid_s = 1'b0;
        halt_s  = 1'b1;
        if (validTri_R13H && box_ok_s) begin
          tri_s      = tri_R13S;
          color_s    = color_R13U;
          ll_x_s     = box_R13S[0][0];
          ur_x_s     = box_R13S[1][0];
          ur_y_s     = box_R13S[1][1];
          step_lg2_s = step_lg2_R13U;
          samp_x_s   = box_R13S[0][0];
          samp_y_s   = box_R13S[0][1];
          valid_s    = 1'b1;
          halt_s     = 1'b0;
          state_s    = ST_TEST;
        end else begin
          state_s    = ST_WAIT;
        end
      end
      ST_TEST: begin
        if (x_fits_s) begin
          samp_x_s = next_x_s[SIGFIG-1:0];
        end else if (y_fits_s) begin
          samp_x_s = ll_x_r;
          samp_y_s = next_y_s[SIGFIG-1:0];
        end else begin
          valid_s  = 1'b0;
          halt_s   = 1'b1;
          state_s  = ST_WAIT;
        end
      end
      default: begin
        valid_s = 1'b0;
        halt_s  = 1'b1;
        state_s = ST_WAIT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_WAIT;
      tri_r      <= '0;
      color_r    <= '0;
      ll_x_r     <= '0;
      ur_x_r     <= '0;
      ur_y_r     <= '0;
      step_lg2_r <= 5'd0;
      samp_x_r   <= '0;
      samp_y_r   <= '0;
      valid_r    <= 1'b0;
      halt_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      tri_r      <= tri_s;
      color_r    <= color_s;
      ll_x_r     <= ll_x_s;
      ur_x_r     <= ur_x_s;
      ur_y_r     <= ur_y_s;
      step_lg2_r <= step_lg2_s;
      samp_x_r   <= samp_x_s;
      samp_y_r   <= samp_y_s;
      valid_r    <= valid_s;
      halt_r     <= halt_s;
    end
  end

endmodule

// File: tb/tb_bbox_sample_iterator.sv
// Self-checking bench: table of directed boxes, hand-written reset/busy
// sequences, and random boxes checked against a nested-loop sample model.
module tb_bbox_sample_iterator;

  localparam int SF = 24;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [2:0][2:0][SF-1:0]    tri_in;
  logic [2:0][SF-1:0]         color_in;
  logic [1:0][1:0][SF-1:0]    box_in;
  logic [4:0]                 step_in;
  logic                       valid_in;
  logic                       halt;
  logic [2:0][2:0][SF-1:0]    tri_out;
  logic [2:0][SF-1:0]         color_out;
  logic [1:0][SF-1:0]         sample_out;
  logic                       vsamp;

  int     vectors    = 0;
  int     miscompares = 0;
  int     got_n;
  longint got_fx, got_fy, got_lx, got_ly;

  always #5 clk = ~clk;

  bbox_sample_iterator #(.SIGFIG(SF), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R13S       (tri_in),
    .color_R13U     (color_in),
    .box_R13S       (box_in),
    .step_lg2_R13U  (step_in),
    .validTri_R13H  (valid_in),
    .halt_RnnnnL    (halt),
    .tri_R14S       (tri_out),
    .color_R14U     (color_out),
    .sample_R14S    (sample_out),
    .validSamp_R14H (vsamp)
  );

  typedef struct {
    longint llx, lly, urx, ury;
    int     sl;
    int     n;
    longint fx, fy, lx, ly;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bits(input string name, input logic [215:0] act, input logic [215:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 3; a++) tri_in[v][a] = SF'($urandom());
      color_in[v] = SF'($urandom());
    end
    for (int c = 0; c < 2; c++) begin
      box_in[c][0] = SF'($urandom());
      box_in[c][1] = SF'($urandom());
    end
    step_in = 5'($urandom_range(0, 10));
  endtask

  // Presents one triangle in the current (halt high) cycle and follows its walk.
  task automatic run_tri(input longint llx, input longint lly, input longint urx,
                         input longint ury, input int sl, input bit noise);
    logic [2:0][2:0][SF-1:0] tv;
    logic [2:0][SF-1:0]      cv;
    logic [215:0]            prev_tri;
    logic [215:0]            exp_tri;
    longint                  qx[$];
    longint                  qy[$];
    longint                  s;
    longint                  ax, ay;
    int                      guard;
    s = longint'(1) << sl;
    for (longint y = lly; y <= ury; y += s)
      for (longint x = llx; x <= urx; x += s) begin
        qx.push_back(x);
        qy.push_back(y);
      end
    prev_tri = tri_out;
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 3; a++) tv[v][a] = SF'($urandom());
      cv[v] = SF'($urandom());
    end
    tri_in       = tv;
    color_in     = cv;
    box_in[0][0] = llx[SF-1:0];
    box_in[0][1] = lly[SF-1:0];
    box_in[1][0] = urx[SF-1:0];
    box_in[1][1] = ury[SF-1:0];
    step_in      = sl[4:0];
    valid_in     = 1'b1;
    tick();
    valid_in = 1'b0;
    randomize_inputs();
    got_n = 0;
    guard = 0;
    while (vsamp === 1'b1 && guard < qx.size() + 4) begin
      ax = longint'($signed(sample_out[0]));
      ay = longint'($signed(sample_out[1]));
      if (got_n < qx.size()) begin
        check("sample x", ax, qx[got_n]);
        check("sample y", ay, qy[got_n]);
      end
      check("halt low during walk", longint'(halt), 0);
      check_bits("tri stable", tri_out, tv);
      check_bits("color stable", 216'(color_out), 216'(cv));
      if (got_n == 0) begin
        got_fx = ax;
        got_fy = ay;
      end
      got_lx = ax;
      got_ly = ay;
      if (noise) begin
        randomize_inputs();
        valid_in = 1'b1;
      end
      got_n++;
      guard++;
      tick();
    end
    valid_in = 1'b0;
    check("sample count", got_n, qx.size());
    check("halt high after walk", longint'(halt), 1);
    check("valid low after walk", longint'(vsamp), 0);
    exp_tri = (qx.size() > 0) ? 216'(tv) : prev_tri;
    check_bits("tri held in wait", tri_out, exp_tri);
  endtask

  initial begin
    tbl[0] = '{llx: 'h400,  lly: 'h800,  urx: 'h400,    ury: 'h800,  sl: 10, n: 1,
               fx: 'h400,   fy: 'h800,   lx: 'h400,     ly: 'h800};
    tbl[1] = '{llx: 0,      lly: 0,      urx: 'h400,    ury: 'h400,  sl: 10, n: 4,
               fx: 0,       fy: 0,       lx: 'h400,     ly: 'h400};
    tbl[2] = '{llx: -'h400, lly: -'h400, urx: 0,        ury: -'h400, sl: 9,  n: 3,
               fx: -'h400,  fy: -'h400,  lx: 0,         ly: -'h400};
    tbl[3] = '{llx: 'h800,  lly: 0,      urx: 'h400,    ury: 'h400,  sl: 10, n: 0,
               fx: 0,       fy: 0,       lx: 0,         ly: 0};
    tbl[4] = '{llx: 0,      lly: 0,      urx: 'hC00,    ury: 'h400,  sl: 10, n: 8,
               fx: 0,       fy: 0,       lx: 'hC00,     ly: 'h400};
    tbl[5] = '{llx: 5,      lly: 5,      urx: 7,        ury: 6,      sl: 0,  n: 6,
               fx: 5,       fy: 5,       lx: 7,         ly: 6};
    tbl[6] = '{llx: 'h7FF800, lly: 0,    urx: 'h7FFC00, ury: 0,      sl: 10, n: 2,
               fx: 'h7FF800, fy: 0,      lx: 'h7FFC00,  ly: 0};

    rst      = 1'b1;
    valid_in = 1'b0;
    tri_in   = '0;
    color_in = '0;
    box_in   = '0;
    step_in  = 5'd0;
    tick();
    tick();
    check("reset halt", longint'(halt), 1);
    check("reset valid", longint'(vsamp), 0);
    check_bits("reset sample", 216'(sample_out), 216'd0);
    check_bits("reset tri", tri_out, 216'd0);
    check_bits("reset color", 216'(color_out), 216'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_tri(tbl[i].llx, tbl[i].lly, tbl[i].urx, tbl[i].ury, tbl[i].sl, 1'b0);
      check("table count", got_n, tbl[i].n);
      if (tbl[i].n > 0) begin
        check("table first x", got_fx, tbl[i].fx);
        check("table first y", got_fy, tbl[i].fy);
        check("table last x", got_lx, tbl[i].lx);
        check("table last y", got_ly, tbl[i].ly);
      end
      tick();
    end

    // Busy ignore, then a back-to-back triangle in the single WAIT cycle.
    run_tri(0, 0, 'h400, 'h400, 10, 1'b1);
    check("busy count", got_n, 4);
    check("busy last x", got_lx, 'h400);
    run_tri('h400, 'h800, 'h400, 'h800, 10, 1'b0);
    check("back-to-back count", got_n, 1);

    // Reset after the second sample of a 2x2 walk.
    tri_in       = '1;
    box_in[0][0] = '0;
    box_in[0][1] = '0;
    box_in[1][0] = 24'h000400;
    box_in[1][1] = 24'h000400;
    step_in      = 5'd10;
    valid_in     = 1'b1;
    tick();
    valid_in = 1'b0;
    check("pre-reset first valid", longint'(vsamp), 1);
    tick();
    check("pre-reset second x", longint'($signed(sample_out[0])), 'h400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-walk reset valid", longint'(vsamp), 0);
    check("mid-walk reset halt", longint'(halt), 1);
    tick();
    check("post-reset still idle", longint'(vsamp), 0);
    run_tri(-'h400, -'h400, 0, -'h400, 9, 1'b0);
    check("post-reset count", got_n, 3);

    // Random boxes, occasionally empty, against the nested-loop model.
    for (int r = 0; r < 40; r++) begin
      int     sl;
      longint s, llx, lly, urx, ury;
      sl  = $urandom_range(0, 10);
      s   = longint'(1) << sl;
      llx = (longint'($urandom_range(0, 40)) - 20) * s;
      lly = (longint'($urandom_range(0, 40)) - 20) * s;
      urx = llx + longint'($urandom_range(0, 4)) * s;
      ury = lly + longint'($urandom_range(0, 3)) * s;
      if ($urandom_range(0, 7) == 0) urx = llx - s;
      run_tri(llx, lly, urx, ury, sl, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bbox_sample_iterator.md
Name: bbox_sample_iterator

Overview:
- Sample generator feeding the per-sample edge-test stage (sampletest) of the rasterizer.
- Accepts one triangle with its precomputed, grid-aligned bounding box.
- Walks the box in raster order (x fastest) at a programmable step, presenting one sample per cycle with the triangle's vertices and color.
- Stalls upstream through an active-low halt while the walk is in progress.

Parameters:
SIGFIG, 24, bits in position/color words (signed fixed point)
RADIX, 10, fraction bits in position
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
tri_R13S  in  [VERTS][AXIS][SIGFIG] signed  triangle vertices
color_R13U  in  [COLORS][SIGFIG] unsigned  triangle color
box_R13S  in  [2][2][SIGFIG] signed  bounding box; [0]=lower-left (x,y), [1]=upper-right (x,y)
step_lg2_R13U  in  5  log2 of sample step in LSBs (valid range 0..RADIX)
validTri_R13H  in  1  triangle/box valid
halt_RnnnnL  out  1  low = busy, upstream must hold; high = ready
tri_R14S  out  [VERTS][AXIS][SIGFIG] signed  latched triangle
color_R14U  out  [COLORS][SIGFIG] unsigned  latched color
sample_R14S  out  [2][SIGFIG] signed  current sample (x,y)
validSamp_R14H  out  1  sample_R14S is a valid sample of tri_R14S

Behaviour:
- Clocking and reset:
  - All state changes on the rising edge of clk.
  - rst is synchronous and active-high.
  - Reset values: state=WAIT, halt_RnnnnL=1, validSamp_R14H=0, all data outputs 0.
- States: WAIT, TEST. All outputs are registered.
- WAIT:
  - Accept when validTri_R13H=1 and the box is non-empty (ll.x<=ur.x and ll.y<=ur.y, signed compare).
  - On accept: latch tri, color, box, step; sample_R14S<=ll; validSamp_R14H<=1; halt_RnnnnL<=0; ->TEST.
  - Latency is 1 cycle from accept to first valid sample.
  - Empty box: triangle dropped, stay in WAIT, no sample emitted, halt stays 1.
- TEST (one sample per cycle, no backpressure from downstream). Let step=1<<step_lg2:
  - sample.x+step<=ur.x: x<=x+step, y unchanged.
  - else sample.y+step<=ur.y: x<=ll.x, y<=y+step.
  - else (current output is the last sample): validSamp_R14H<=0, halt_RnnnnL<=1, ->WAIT.
- Sample count per triangle is exactly ((ur.x-ll.x)>>step_lg2 + 1) * ((ur.y-ll.y)>>step_lg2 + 1).
  - halt_RnnnnL is low for exactly that many cycles.
- Arithmetic:
  - Next-x and next-y sums are computed in SIGFIG+1 bits signed, so a sum at the top of range does not wrap into a false "<=" pass.
  - Box corners are aligned to the step grid upstream; no rounding is done here.
- Upstream handshake:
  - A new triangle may be presented only while halt_RnnnnL=1.
  - validTri_R13H during TEST is ignored; latched data is unaffected.
  - Back-to-back triangles are separated by one WAIT cycle (the cycle in which halt_RnnnnL returns high).
- Stability: tri_R14S and color_R14U stay constant throughout a walk and hold their last value in WAIT.
- Reset mid-walk: the next cycle is WAIT with validSamp_R14H=0 and halt_RnnnnL=1; the remaining samples are discarded.
- step_lg2_R13U>RADIX is not supported; no check is made.

Test Plan:
- Single sample: box ll=ur=(0x400,0x800), step_lg2=10 -> one cycle of validSamp=1 with sample (0x400,0x800); halt_L low 1 cycle; then WAIT.
- 2x2 pixels: ll=(0,0), ur=(0x400,0x400), step_lg2=10 -> samples (0,0),(0x400,0),(0,0x400),(0x400,0x400) on 4 consecutive cycles; halt_L low exactly 4 cycles.
- Subsample, negative coords: ll=(-0x400,-0x400), ur=(0,-0x400), step_lg2=9 -> x=-0x400,-0x200,0 at y=-0x400; 3 valid cycles.
- Busy ignore: assert validTri with a different box during the 2x2 walk -> same 4 samples, tri_R14S unchanged; the next triangle is accepted only when halt_L=1.
- Empty box: ll=(0x800,0), ur=(0x400,0x400) -> validSamp never asserted; halt_L stays 1.
- Reset mid-walk: rst after the 2nd sample of the 2x2 case -> next cycle validSamp=0, halt_L=1; a new triangle presented afterwards produces its full sample sequence.
